// File: rtl/sobel_edge_stream.sv
// Streaming Sobel edge detector: RGB -> luma -> 3x3 window over two line buffers -> |Gx|+|Gy|
// threshold. Flushes the final row internally after the last input and pulses o_frame_done.
module sobel_edge_stream #(
    parameter int unsigned IMG_WIDTH  = 160,
    parameter int unsigned IMG_HEIGHT = 120,
    parameter logic [10:0] THRESHOLD  = 11'd128
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      i_de,
    input  logic [7:0]                                i_r,
    input  logic [7:0]                                i_g,
    input  logic [7:0]                                i_b,
    output logic                                      o_de,
    output logic                                      o_edge,
    output logic [7:0]                                o_gray,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0]   o_pix_cnt,
    output logic                                      o_frame_done
);

    localparam int unsigned NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned PIX_W = $clog2(NPIX);
    localparam int unsigned XW    = $clog2(IMG_WIDTH);
    localparam int unsigned YW    = $clog2(IMG_HEIGHT);
    localparam int unsigned FW    = $clog2(IMG_WIDTH + 1);
    localparam int unsigned WW    = $clog2(IMG_WIDTH + 2);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
    localparam logic [XW-1:0]    X_LAST   = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]    Y_LAST   = YW'(IMG_HEIGHT - 1);
    localparam logic [FW-1:0]    F_LAST   = FW'(IMG_WIDTH);
    localparam logic [WW-1:0]    WARM     = WW'(IMG_WIDTH + 1);

    typedef enum logic [1:0] {StRun, StFlush, StDone} state_e;

    state_e           state_q, state_d;
    logic [PIX_W-1:0] in_cnt_q, in_cnt_d;
    logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
    logic             adv, flush, frame_clr;

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        flush_cnt_d = flush_cnt_q;
        adv         = 1'b0;
        flush       = 1'b0;
        frame_clr   = 1'b0;
        unique case (state_q)
            StRun: begin
                if (i_de) begin
                    adv = 1'b1;
                    if (in_cnt_q == PIX_LAST) begin
                        in_cnt_d = '0;
                        state_d  = StFlush;
                    end else begin
                        in_cnt_d = in_cnt_q + PIX_W'(1);
                    end
                end
            end
            StFlush: begin
                adv   = 1'b1;
                flush = 1'b1;
                if (flush_cnt_q == F_LAST) begin
                    flush_cnt_d = '0;
                    state_d     = StDone;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            StDone: begin
                // Last output is on the port this cycle; restart counters for the next frame.
                if (o_de && (o_pix_cnt == PIX_LAST)) begin
                    frame_clr = 1'b1;
                    state_d   = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            in_cnt_q     <= '0;
            flush_cnt_q  <= '0;
            o_frame_done <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            o_frame_done <= frame_clr;
        end
    end

    // Stage 1: luma
    logic [15:0] luma_sum;
    logic [7:0]  luma;
    logic        s1_valid, s1_flush;
    logic [7:0]  s1_gray;

    assign luma_sum = 16'd77 * {8'd0, i_r} + 16'd150 * {8'd0, i_g} + 16'd29 * {8'd0, i_b};
    assign luma     = 8'(luma_sum >> 8);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_flush <= 1'b0;
            s1_gray  <= '0;
        end else begin
            s1_valid <= adv;
            s1_flush <= flush;
            if (adv) s1_gray <= flush ? 8'd0 : luma;
        end
    end

    // Stage 2: line buffers, window shift, centre bookkeeping
    logic [7:0]       lb0 [IMG_WIDTH];
    logic [7:0]       lb1 [IMG_WIDTH];
    logic [7:0]       p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic [XW-1:0]    lb_col;
    logic [WW-1:0]    warm_cnt;
    logic [XW-1:0]    c_x;
    logic [YW-1:0]    c_y;
    logic [PIX_W-1:0] c_idx;
    logic             s2_valid, s2_border;
    logic [PIX_W-1:0] s2_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lb_col    <= '0;
            warm_cnt  <= '0;
            c_x       <= '0;
            c_y       <= '0;
            c_idx     <= '0;
            s2_valid  <= 1'b0;
            s2_border <= 1'b0;
            s2_idx    <= '0;
        end else begin
            s2_valid <= 1'b0;
            if (frame_clr) begin
                lb_col   <= '0;
                warm_cnt <= '0;
                c_x      <= '0;
                c_y      <= '0;
                c_idx    <= '0;
            end else if (s1_valid) begin
                lb_col <= (lb_col == X_LAST) ? '0 : lb_col + XW'(1);
                // The first W+1 advances only prime the window; no centre exists yet.
                if (warm_cnt != WARM) begin
                    warm_cnt <= warm_cnt + WW'(1);
                end else begin
                    s2_valid  <= 1'b1;
                    s2_border <= (c_x == '0) || (c_x == X_LAST) || (c_y == '0) || (c_y == Y_LAST);
                    s2_idx    <= c_idx;
                    c_idx     <= c_idx + PIX_W'(1);
                    if (c_x == X_LAST) begin
                        c_x <= '0;
                        c_y <= c_y + YW'(1);
                    end else begin
                        c_x <= c_x + XW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid) begin
            if (!s1_flush) begin
                lb0[lb_col] <= s1_gray;
                lb1[lb_col] <= lb0[lb_col];
            end
            p00 <= p01;
            p01 <= p02;
            p02 <= lb1[lb_col];
            p10 <= p11;
            p11 <= p12;
            p12 <= lb0[lb_col];
            p20 <= p21;
            p21 <= p22;
            p22 <= s1_gray;
        end
    end

    // Stage 3: gradients
    logic signed [10:0] gx_c, gy_c, s3_gx, s3_gy;
    logic               s3_valid, s3_border;
    logic [PIX_W-1:0]   s3_idx;
    logic [7:0]         s3_gray;

    assign gx_c = $signed({3'b000, p02}) + $signed({2'b00, p12, 1'b0}) + $signed({3'b000, p22})
                - $signed({3'b000, p00}) - $signed({2'b00, p10, 1'b0}) - $signed({3'b000, p20});
    assign gy_c = $signed({3'b000, p20}) + $signed({2'b00, p21, 1'b0}) + $signed({3'b000, p22})
                - $signed({3'b000, p00}) - $signed({2'b00, p01, 1'b0}) - $signed({3'b000, p02});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_valid  <= 1'b0;
            s3_border <= 1'b0;
            s3_idx    <= '0;
            s3_gray   <= '0;
            s3_gx     <= '0;
            s3_gy     <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_border <= s2_border;
                s3_idx    <= s2_idx;
                s3_gray   <= p11;
                s3_gx     <= gx_c;
                s3_gy     <= gy_c;
            end
        end
    end

    // Stage 4: magnitude, threshold, outputs
    logic [10:0] abs_gx, abs_gy, mag;

    assign abs_gx = s3_gx[10] ? $unsigned(-s3_gx) : $unsigned(s3_gx);
    assign abs_gy = s3_gy[10] ? $unsigned(-s3_gy) : $unsigned(s3_gy);
    assign mag    = abs_gx + abs_gy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_de      <= 1'b0;
            o_edge    <= 1'b0;
            o_gray    <= '0;
            o_pix_cnt <= '0;
        end else begin
            o_de   <= s3_valid;
            o_edge <= s3_valid && !s3_border && (mag >= THRESHOLD);
            if (s3_valid) begin
                o_gray    <= s3_gray;
                o_pix_cnt <= s3_idx;
            end
        end
    end

endmodule
